// File: rtl/ct_cp0_rst_inv_ctrl.sv
// CP0 reset-time cache invalidate walker and reset-vector-base latch for the IFU.
// Define CT_CP0_RST_DINV_EN to follow the I-cache walk with a D-cache walk before done.
module ct_cp0_rst_inv_ctrl #(
  parameter int unsigned ICACHE_IDX_W = 8,
  parameter int unsigned DCACHE_IDX_W = 8
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    ifu_cp0_rst_inv_req,
  input  logic                    ifu_cp0_rst_mrvbr_req,
  input  logic [39:0]             pad_cpu_rvba,
  input  logic                    ifu_cp0_icache_inv_grnt,
  input  logic                    dcache_cp0_inv_grnt,
  output logic                    cp0_ifu_icache_inv_vld,
  output logic [ICACHE_IDX_W-1:0] cp0_ifu_icache_inv_idx,
  output logic                    cp0_dcache_inv_vld,
  output logic [DCACHE_IDX_W-1:0] cp0_dcache_inv_idx,
  output logic                    cp0_ifu_rst_inv_done,
  output logic [39:0]             cp0_ifu_rvbr,
  output logic                    cp0_yy_rst_inv_busy
);

  localparam logic [3:0] IDLE = 4'b0001;
  localparam logic [3:0] IINV = 4'b0010;
`ifdef CT_CP0_RST_DINV_EN
  localparam logic [3:0] DINV = 4'b0100;
`endif
  localparam logic [3:0] DONE = 4'b1000;

  logic [3:0]              r_state;
  logic [3:0]              w_state_nxt;
  logic [ICACHE_IDX_W-1:0] r_icnt;
  logic [ICACHE_IDX_W-1:0] w_icnt_nxt;
  logic                    w_ilast;
  logic [39:0]             r_rvbr;
  logic [1:0]              w_unused_rvba_lsb;

  assign w_ilast           = (r_icnt == '1);
  assign w_unused_rvba_lsb = pad_cpu_rvba[1:0];

`ifdef CT_CP0_RST_DINV_EN
  logic [DCACHE_IDX_W-1:0] r_dcnt;
  logic [DCACHE_IDX_W-1:0] w_dcnt_nxt;
  logic                    w_dlast;

  assign w_dlast = (r_dcnt == '1);
`else
  logic w_unused_dgrnt;

  assign w_unused_dgrnt = dcache_cp0_inv_grnt;
`endif

  // A request in any state restarts the walk from index 0.
  always_comb begin
    w_state_nxt = r_state;
    w_icnt_nxt  = r_icnt;
`ifdef CT_CP0_RST_DINV_EN
    w_dcnt_nxt  = r_dcnt;
`endif
    if (ifu_cp0_rst_inv_req) begin
      w_state_nxt = IINV;
      w_icnt_nxt  = '0;
`ifdef CT_CP0_RST_DINV_EN
      w_dcnt_nxt  = '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: w_state_nxt = IDLE;
        IINV: begin
          if (ifu_cp0_icache_inv_grnt) begin
            w_icnt_nxt = r_icnt + ICACHE_IDX_W'(1);
            if (w_ilast) begin
`ifdef CT_CP0_RST_DINV_EN
              w_state_nxt = DINV;
`else
              w_state_nxt = DONE;
`endif
            end
          end
        end
`ifdef CT_CP0_RST_DINV_EN
        DINV: begin
          if (dcache_cp0_inv_grnt) begin
            w_dcnt_nxt = r_dcnt + DCACHE_IDX_W'(1);
            if (w_dlast) begin
              w_state_nxt = DONE;
            end
          end
        end
`endif
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= IDLE;
      r_icnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_icnt  <= w_icnt_nxt;
    end
  end

`ifdef CT_CP0_RST_DINV_EN
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_dcnt <= '0;
    end else begin
      r_dcnt <= w_dcnt_nxt;
    end
  end
`endif

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rvbr <= 40'h0;
    end else if (ifu_cp0_rst_mrvbr_req) begin
      r_rvbr <= {pad_cpu_rvba[39:2], 2'b00};
    end
  end

  assign cp0_ifu_icache_inv_vld = r_state[1];
  assign cp0_ifu_icache_inv_idx = r_icnt;
`ifdef CT_CP0_RST_DINV_EN
  assign cp0_dcache_inv_vld     = r_state[2];
  assign cp0_dcache_inv_idx     = r_dcnt;
`else
  assign cp0_dcache_inv_vld     = 1'b0;
  assign cp0_dcache_inv_idx     = '0;
`endif
  // A request landing in DONE restarts the walk, so that completion must not be reported.
  assign cp0_ifu_rst_inv_done   = r_state[3] & ~ifu_cp0_rst_inv_req;
  assign cp0_ifu_rvbr           = r_rvbr;
  assign cp0_yy_rst_inv_busy    = ~r_state[0];

endmodule
